spi_byte_master: RTL and testbench

- Mode-0 (CPOL=0, CPHA=0) SPI master that performs one full-duplex 8-bit exchange per request, MSB first.
- Sits directly upstream of the serial-protocol controller.
  - It feeds that controller each received byte plus a one-cycle new-data strobe.
  - It takes the controller's next outgoing byte on the i_Data bus.
- Owns the CS, CLK and MOSI pads and the MISO input.

---
 rtl/spi_byte_master.sv | 130 +++++++++++++
 tb/tb_spi_byte_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - Mode-0 SPI byte master, MSB first, one full-duplex byte per request.
// Define SPI_LOOPBACK_EN to sample o_MOSI instead of i_MISO on SCLK rising edges.
module spi_byte_master #(
  parameter int CLK_DIV        = 4,
  parameter int CS_IDLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_Reset_n,
  input  logic [7:0] i_Data,
  input  logic       i_Start,
  output logic [7:0] o_Data,
  output logic       o_New_Data_Enable,
  output logic       o_Busy,
  output logic       o_CS,
  output logic       o_CLK,
  output logic       o_MOSI,
  input  logic       i_MISO
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LEN    = 8'(CS_IDLE_CYCLES);

  logic [2:0] state;
  logic [7:0] div_cnt;
  logic [7:0] gap_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] tx_sr;   // bit 7 goes straight to o_MOSI on the start edge
  logic [7:0] rx_sr;
  logic       tick;
  logic       rx_bit;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = i_MISO;
  assign rx_bit      = o_MOSI;
`else
  assign rx_bit = i_MISO;
`endif

  assign tick   = (div_cnt == 8'd0);
  assign o_Busy = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state             <= S_IDLE;
      div_cnt           <= 8'd0;
      gap_cnt           <= 8'd0;
      bit_cnt           <= 3'd0;
      tx_sr             <= 7'd0;
      rx_sr             <= 8'd0;
      o_Data            <= 8'h00;
      o_New_Data_Enable <= 1'b0;
      o_CS              <= 1'b1;
      o_CLK             <= 1'b0;
      o_MOSI            <= 1'b0;
    end else begin
      o_New_Data_Enable <= 1'b0;
      if (state == S_SETUP || state == S_SHIFT || state == S_HOLD) begin
        div_cnt <= tick ? DIV_RELOAD : div_cnt - 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (i_Start) begin
            tx_sr   <= i_Data[6:0];
            o_MOSI  <= i_Data[7];
            o_CS    <= 1'b0;
            div_cnt <= DIV_RELOAD;
            bit_cnt <= 3'd0;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tick) begin
            o_CLK <= 1'b1;
            rx_sr <= {rx_sr[6:0], rx_bit};
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (tick) begin
            if (!o_CLK) begin
              o_CLK <= 1'b1;
              rx_sr <= {rx_sr[6:0], rx_bit};
            end else begin
              o_CLK   <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              // After the eighth fall MOSI keeps bit 0 through HOLD.
              if (bit_cnt == 3'd7) begin
                state <= S_HOLD;
              end else begin
                o_MOSI <= tx_sr[6];
                tx_sr  <= {tx_sr[5:0], 1'b0};
              end
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            o_CS              <= 1'b1;
            o_Data            <= rx_sr;
            o_New_Data_Enable <= 1'b1;
            o_MOSI            <= 1'b0;
            if (GAP_LEN == 8'd0) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= GAP_LEN - 8'd1;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb/tb_spi_byte_master.sv - Bench for spi_byte_master: three dividers against a timing-formula model.
module tb_spi_byte_master;

  localparam int NI  = 3;
  localparam int GAP = 2;
`ifdef SPI_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  function automatic int div_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 255);
  endfunction

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] start;
  logic [NI-1:0] miso;
  logic [7:0]    data [NI];
  logic [7:0]    rdata [NI];
  logic [NI-1:0] strobe, busy, cs, sclk, mosi;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_byte_master #(.CLK_DIV(div_of(g)), .CS_IDLE_CYCLES(GAP)) u_dut (
      .i_clk(clk), .i_Reset_n(rst_n), .i_Data(data[g]), .i_Start(start[g]),
      .o_Data(rdata[g]), .o_New_Data_Enable(strobe[g]), .o_Busy(busy[g]),
      .o_CS(cs[g]), .o_CLK(sclk[g]), .o_MOSI(mosi[g]), .i_MISO(miso[g]));
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input int g, input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL u%0d %s: got %0h expected %0h", g, nm, got, want);
    end
  endtask

  // Reference model: a transfer is its start cycle plus the captured bytes; pins follow from k = cycle - start.
  int         cyc = 0;
  bit         act [NI];
  int         n [NI];
  logic [7:0] tx [NI], sb [NI], erx [NI], edata [NI], slave [NI];

  always @(posedge clk) begin
    int k, d;
    cyc++;
    for (int g = 0; g < NI; g++) begin
      d = div_of(g);
      k = cyc - n[g];
      if (!rst_n) begin
        act[g]   = 1'b0;
        edata[g] = 8'h00;
      end else begin
        if (act[g] && k == 17 * d) edata[g] = erx[g];
        if (act[g] && k > 17 * d + GAP) act[g] = 1'b0;
        if (!act[g] && start[g]) begin
          act[g] = 1'b1;
          n[g]   = cyc;
          tx[g]  = data[g];
          sb[g]  = slave[g];
          erx[g] = LOOP ? data[g] : slave[g];
        end
      end
    end
  end

  // Observations of the pins, reset whenever the stimulus bumps epoch.
  int         epoch = 0, seen_epoch = -1;
  logic       prev_sclk [NI];
  int         rise_cnt [NI], first_rise [NI], last_rise [NI];
  int         strobe_cnt [NI], last_strobe [NI], strobe_gap [NI];
  int         cs_run [NI], last_cs_run [NI], mosi_hi [NI];
  bit         had_low [NI];
  logic [7:0] mosi_cap [NI];

  always @(negedge clk) begin
    int d, k;
    logic e_cs, e_clk, e_mosi, e_stb, e_busy;
    for (int g = 0; g < NI; g++) begin
      d = div_of(g);
      k = cyc - n[g];
      e_cs = 1'b1; e_clk = 1'b0; e_mosi = 1'b0; e_stb = 1'b0; e_busy = 1'b0;
      if (act[g]) begin
        e_busy = (k < 17 * d + GAP);
        e_cs   = (k >= 17 * d);
        e_clk  = (k >= d) && (k < 16 * d) && ((k / d) % 2 == 1);
        if (k < 16 * d) e_mosi = tx[g][7 - k / (2 * d)];
        else if (k < 17 * d) e_mosi = tx[g][0];
        e_stb  = (k == 17 * d);
      end
      if (rst_n) begin
        chk(g, "cs", cs[g], e_cs);
        chk(g, "sclk", sclk[g], e_clk);
        chk(g, "mosi", mosi[g], e_mosi);
        chk(g, "strobe", strobe[g], e_stb);
        chk(g, "busy", busy[g], e_busy);
        chk(g, "data", rdata[g], edata[g]);
      end
      if (!LOOP && act[g] && k < 16 * d) miso[g] = sb[g][7 - k / (2 * d)];
      else miso[g] = LOOP ? 1'b0 : 1'($urandom_range(1));

      if (seen_epoch != epoch) begin
        prev_sclk[g] = 1'b0; rise_cnt[g] = 0; first_rise[g] = 0; last_rise[g] = 0;
        strobe_cnt[g] = 0; last_strobe[g] = 0; strobe_gap[g] = 0;
        cs_run[g] = 0; last_cs_run[g] = 0; mosi_hi[g] = 0; had_low[g] = 1'b0; mosi_cap[g] = 8'h00;
      end
      if (sclk[g] === 1'b1 && prev_sclk[g] !== 1'b1) begin
        rise_cnt[g]++;
        if (rise_cnt[g] == 1) first_rise[g] = cyc;
        last_rise[g] = cyc;
        mosi_cap[g]  = {mosi_cap[g][6:0], mosi[g]};
      end
      prev_sclk[g] = sclk[g];
      if (strobe[g] === 1'b1) begin
        if (strobe_cnt[g] > 0) strobe_gap[g] = cyc - last_strobe[g];
        strobe_cnt[g]++;
        last_strobe[g] = cyc;
      end
      if (cs[g] === 1'b1) cs_run[g]++;
      else begin
        if (had_low[g] && cs_run[g] > 0) last_cs_run[g] = cs_run[g];
        cs_run[g]  = 0;
        had_low[g] = 1'b1;
      end
      if (mosi[g] === 1'b1) mosi_hi[g]++;
    end
    seen_epoch = epoch;
  end

  initial begin
    int nstart, ok;
    logic [7:0] s1, s2;
    start = '0;
    for (int g = 0; g < NI; g++) begin
      data[g] = 8'h00; slave[g] = 8'h00;
    end

    repeat (3) @(negedge clk);
    chk(0, "reset cs", cs[0], 1'b1);
    chk(0, "reset sclk", sclk[0], 1'b0);
    chk(0, "reset mosi", mosi[0], 1'b0);
    chk(0, "reset data", rdata[0], 8'h00);
    chk(0, "reset busy", busy[0], 1'b0);
    chk(0, "reset strobe", strobe[0], 1'b0);
    #2 rst_n = 1'b1;

    // Single exchange with an ignored second request at N+10.
    @(negedge clk);
    epoch++;
    data[0] = 8'h3C; slave[0] = 8'hA5; start[0] = 1'b1; nstart = cyc + 1;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < nstart + 9) @(negedge clk);
    start[0] = 1'b1; data[0] = 8'h55;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < nstart + 80) @(negedge clk);
    chk(0, "single strobe count", strobe_cnt[0], 1);
    chk(0, "single strobe cycle", last_strobe[0], nstart + 68);
    chk(0, "single rise count", rise_cnt[0], 8);
    chk(0, "single first rise", first_rise[0], nstart + 4);
    chk(0, "single last rise", last_rise[0], nstart + 60);
    chk(0, "single mosi byte", mosi_cap[0], 8'h3C);
    chk(0, "single rx byte", rdata[0], LOOP ? 8'h3C : 8'hA5);

    // Back-to-back on the CLK_DIV=1 instance.
    epoch++;
    s1 = 8'($urandom); s2 = 8'($urandom);
    data[1] = 8'h01; slave[1] = s1; start[1] = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (strobe[1] === 1'b1) begin ok = 1; break; end
    end
    chk(1, "b2b first strobe seen", ok, 1);
    data[1] = 8'hFF; slave[1] = s2;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (strobe[1] === 1'b1) begin ok = 1; break; end
    end
    chk(1, "b2b second strobe seen", ok, 1);
    start[1] = 1'b0;
    repeat (6) @(negedge clk);
    chk(1, "b2b strobe count", strobe_cnt[1], 2);
    chk(1, "b2b strobe spacing", strobe_gap[1], 20);
    chk(1, "b2b cs high run", last_cs_run[1], 3);
    chk(1, "b2b second rx", rdata[1], LOOP ? 8'hFF : s2);
    chk(1, "b2b second mosi", mosi_cap[1], 8'hFF);

    // Random traffic on the CLK_DIV=4 instance, including late i_Data changes.
    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(6)) @(negedge clk);
      data[0] = 8'($urandom); slave[0] = 8'($urandom); start[0] = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      start[0] = 1'b0; data[0] = 8'($urandom);
      repeat (17 * 4 + GAP + 2) @(negedge clk);
    end

    // Reset in the middle of SHIFT.
    epoch++;
    data[0] = 8'($urandom); slave[0] = 8'($urandom); start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "abort cs", cs[0], 1'b1);
    chk(0, "abort sclk", sclk[0], 1'b0);
    chk(0, "abort mosi", mosi[0], 1'b0);
    chk(0, "abort data", rdata[0], 8'h00);
    chk(0, "abort busy", busy[0], 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk(0, "abort no strobe", strobe_cnt[0], 0);
    chk(0, "abort data held", rdata[0], 8'h00);

    // Slowest divider.
    epoch++;
    data[2] = 8'h80; slave[2] = 8'($urandom); start[2] = 1'b1; nstart = cyc + 1;
    @(negedge clk);
    start[2] = 1'b0;
    while (cyc < nstart + 4345) @(negedge clk);
    chk(2, "slow strobe count", strobe_cnt[2], 1);
    chk(2, "slow strobe cycle", last_strobe[2], nstart + 4335);
    chk(2, "slow rise count", rise_cnt[2], 8);
    chk(2, "slow mosi high cycles", mosi_hi[2], 510);

`ifdef SPI_LOOPBACK_EN
    epoch++;
    data[0] = 8'hF7; slave[0] = 8'h00; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (17 * 4 + GAP + 4) @(negedge clk);
    chk(0, "loopback strobe count", strobe_cnt[0], 1);
    chk(0, "loopback rx", rdata[0], 8'hF7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
